// File: rtl/clock_gate_sequencer_pkg.sv
// Shared clock-control definitions: sequencer state encodings, default
// wake/idle timing, and the counter-width helper used by the clock primitives.
package clock_gate_sequencer_pkg;

    typedef enum logic [1:0] {
        CGS_OFF   = 2'd0,
        CGS_WAKE  = 2'd1,
        CGS_ON    = 2'd2,
        CGS_DRAIN = 2'd3
    } cgs_state_e;

    localparam int unsigned CGS_WAKE_CYCLES_DEFAULT = 4;
    localparam int unsigned CGS_IDLE_CYCLES_DEFAULT = 16;

    // Bits needed to hold the larger of the two load values.
    function automatic int unsigned cgs_cnt_width(input int unsigned wake,
                                                  input int unsigned idle);
        int unsigned longest;
        longest = (wake > idle) ? wake : idle;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/clock_gate_sequencer_timer.sv
// Loadable down-counter with zero flag; saturates at zero rather than wrapping.
module clock_gate_sequencer_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clock_gate_sequencer.sv
// Clock-gate sequencer: wakes the downstream gated clock on request, grants
// requesters once it is stable, and shuts it off after an idle period.
module clock_gate_sequencer
    import clock_gate_sequencer_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned WAKE_CYCLES = CGS_WAKE_CYCLES_DEFAULT,
    parameter int unsigned IDLE_CYCLES = CGS_IDLE_CYCLES_DEFAULT,
    parameter bit          BYPASS      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            force_on,
    output logic [NREQ-1:0] ack,
    output logic            clk_en,
    output logic [1:0]      state_o
);

    localparam int unsigned      CNT_W      = cgs_cnt_width(WAKE_CYCLES, IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(IDLE_CYCLES - 1);

    cgs_state_e       state;
    cgs_state_e       next_state;
    logic             demand;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_dec;
    logic             timer_zero;

    assign demand = (|req) || force_on;

    clock_gate_sequencer_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(timer_value),
        .dec       (timer_dec),
        .zero      (timer_zero)
    );

    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        timer_dec   = 1'b0;
        case (state)
            CGS_OFF: begin
                if (demand) begin
                    next_state  = CGS_WAKE;
                    timer_load  = 1'b1;
                    timer_value = WAKE_LOAD;
                end
            end
            CGS_WAKE: begin
                if (timer_zero) begin
                    next_state = CGS_ON;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            CGS_ON: begin
                if (!demand) begin
                    next_state  = CGS_DRAIN;
                    timer_load  = 1'b1;
                    timer_value = IDLE_LOAD;
                end
            end
            CGS_DRAIN: begin
                // New demand outranks the idle timeout expiring on the same edge.
                if (demand) begin
                    next_state = CGS_ON;
                end else if (timer_zero) begin
                    next_state = CGS_OFF;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: next_state = CGS_OFF;
        endcase
    end

    // Grants only load while ON, so a grant never outlives a running clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CGS_OFF;
            ack    <= '0;
            clk_en <= BYPASS;
        end else begin
            state  <= next_state;
            ack    <= (state == CGS_ON) ? req : '0;
            clk_en <= BYPASS || (next_state != CGS_OFF);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_clock_gate_sequencer.sv
// Bench for clock_gate_sequencer: reset/wake vector table, directed drain,
// rescue and force sequences, then randomized traffic against a timestamp model.
module tb_clock_gate_sequencer;

    localparam int WAKE = 4;
    localparam int IDLE = 16;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       force_on;
    logic [3:0] ack;
    logic       clk_en;
    logic [1:0] state_o;

    int checks;
    int failures;

    clock_gate_sequencer #(
        .NREQ       (4),
        .WAKE_CYCLES(WAKE),
        .IDLE_CYCLES(IDLE),
        .BYPASS     (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .force_on(force_on),
        .ack     (ack),
        .clk_en  (clk_en),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the edge at which waking / draining began and
    // derives the phase from elapsed edges.
    int         cyc;
    int         wake_edge;
    int         drain_edge;
    int         m_phase;    // 0 off, 1 waking, 2 running, 3 draining
    logic [3:0] m_ack;
    logic       m_en;

    task automatic model_edge(input logic r, input logic [3:0] rq, input logic f);
        bit was_running;
        bit want;
        want        = (rq != 4'b0) || f;
        was_running = (m_phase == 2);
        if (r) begin
            m_phase = 0;
            m_ack   = 4'b0;
            m_en    = 1'b0;
        end else begin
            m_ack = was_running ? rq : 4'b0;
            if (m_phase == 0) begin
                if (want) begin
                    m_phase   = 1;
                    wake_edge = cyc;
                end
            end else if (m_phase == 1) begin
                if (cyc - wake_edge >= WAKE) m_phase = 2;
            end else if (m_phase == 2) begin
                if (!want) begin
                    m_phase    = 3;
                    drain_edge = cyc;
                end
            end else begin
                if (want) m_phase = 2;
                else if (cyc - drain_edge >= IDLE) m_phase = 0;
            end
            m_en = (m_phase != 0);
        end
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic f);
        rst      = r;
        req      = rq;
        force_on = f;
        @(posedge clk);
        model_edge(r, rq, f);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] e_ack,
                              input logic e_en, input logic [1:0] e_st);
        chk({name, ".ack"}, int'(ack), int'(e_ack));
        chk({name, ".clk_en"}, int'(clk_en), int'(e_en));
        chk({name, ".state"}, int'(state_o), int'(e_st));
    endtask

    task automatic expect_model(input string name);
        expect_out(name, m_ack, m_en, m_phase[1:0]);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       force_on;
        logic [3:0] ack;
        logic       clk_en;
        logic [1:0] state;
    } vec_t;

    vec_t vecs[9];

    initial begin
        checks = 0; failures = 0;
        cyc = 0; wake_edge = 0; drain_edge = 0;
        m_phase = 0; m_ack = 4'b0; m_en = 1'b0;
        rst = 1'b1; req = 4'b0; force_on = 1'b0;

        // Reset, then req[0] from edge 0: WAKE after 0, ON after 4, ack after 5.
        vecs[0] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[2] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[3] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[4] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[5] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[6] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[7] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd2};
        vecs[8] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd2};
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].force_on);
            expect_out($sformatf("vec%0d", i), vecs[i].ack, vecs[i].clk_en, vecs[i].state);
        end

        // Drain to OFF: DRAIN through D0+15, OFF at D0+16.
        step(1'b0, 4'b0000, 1'b0);
        expect_out("drain.d0", 4'b0000, 1'b1, 2'd3);
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 4'b0000, 1'b0);
            expect_out($sformatf("drain.d%0d", k), 4'b0000, 1'b1, 2'd3);
        end
        step(1'b0, 4'b0000, 1'b0);
        expect_out("drain.off", 4'b0000, 1'b0, 2'd0);

        // req[0] from OFF, req[3] joins during WAKE: both acks on edge 5.
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b0);
        expect_out("late.e4", 4'b0000, 1'b1, 2'd2);
        step(1'b0, 4'b1001, 1'b0);
        expect_out("late.e5", 4'b1001, 1'b1, 2'd2);

        // Rescue from DRAIN at counter 5 (edge D0+11).
        step(1'b0, 4'b0000, 1'b0);
        expect_out("resc.d0", 4'b0000, 1'b1, 2'd3);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 4'b0000, 1'b0);
            chk($sformatf("resc.en%0d", k), int'(clk_en), 1);
        end
        step(1'b0, 4'b0100, 1'b0);
        expect_out("resc.on", 4'b0000, 1'b1, 2'd2);
        step(1'b0, 4'b0100, 1'b0);
        expect_out("resc.ack", 4'b0100, 1'b1, 2'd2);

        // Request on the very edge the idle timer expires: request wins.
        step(1'b0, 4'b0000, 1'b0);
        for (int k = 1; k <= 15; k++) step(1'b0, 4'b0000, 1'b0);
        expect_out("edge.d15", 4'b0000, 1'b1, 2'd3);
        step(1'b0, 4'b0010, 1'b0);
        expect_out("edge.on", 4'b0000, 1'b1, 2'd2);
        step(1'b0, 4'b0010, 1'b0);
        expect_out("edge.ack", 4'b0010, 1'b1, 2'd2);

        // Reset while fully granted, requests held: rewake after release.
        step(1'b0, 4'b1111, 1'b0);
        expect_out("rst.full", 4'b1111, 1'b1, 2'd2);
        step(1'b1, 4'b1111, 1'b0);
        expect_out("rst.hit", 4'b0000, 1'b0, 2'd0);
        step(1'b0, 4'b1111, 1'b0);
        expect_out("rst.e0", 4'b0000, 1'b1, 2'd1);
        for (int k = 1; k <= 3; k++) step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        expect_out("rst.e4", 4'b0000, 1'b1, 2'd2);
        step(1'b0, 4'b1111, 1'b0);
        expect_out("rst.e5", 4'b1111, 1'b1, 2'd2);

        // force_on alone: wakes, stays ON without grants, drains after release.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        expect_out("frc.e0", 4'b0000, 1'b1, 2'd1);
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 4'b0000, 1'b1);
            if (k >= 4) expect_out($sformatf("frc.on%0d", k), 4'b0000, 1'b1, 2'd2);
        end
        step(1'b0, 4'b0000, 1'b0);
        expect_out("frc.d0", 4'b0000, 1'b1, 2'd3);
        for (int k = 1; k <= 15; k++) step(1'b0, 4'b0000, 1'b0);
        expect_out("frc.d15", 4'b0000, 1'b1, 2'd3);
        step(1'b0, 4'b0000, 1'b0);
        expect_out("frc.off", 4'b0000, 1'b0, 2'd0);

        // Randomized traffic in phases, checked every edge against the model.
        for (int p = 0; p < 80; p++) begin
            int kind;
            int len;
            logic [3:0] held;
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 25));
            held = 4'($urandom_range(1, 15));
            for (int k = 0; k < len; k++) begin
                case (kind)
                    0:       step(k < 2, 4'($urandom_range(0, 15)), 1'b0);
                    1, 2, 3: step(1'b0, 4'b0000, 1'b0);
                    4, 5, 6: step(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
                    7:       step(1'b0, 4'b0000, 1'b1);
                    default: step(1'b0, held, 1'b0);
                endcase
                expect_model($sformatf("rnd%0d.%0d", p, k));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
